memory_game_ctrl: RTL

Sequencing controller for the 4x4 memory-card board. Owns the game state of all 16 card slots and the player cursor, and decides which cards the per-slot card renderers draw face-up. Consumes one-cycle debounced button pulses and a 48-bit shuffled layout. Drives cursor position, face-up/matched masks, move count and end-of-game flags to the VGA compositing logic. Slot index matches the renderer `pos` encoding: row = idx[3:2], column = idx[1:0], slot 0 at top-left.

---
 rtl/memory_game_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/memory_game_ctrl.sv
// rtl/memory_game_ctrl.sv - 4x4 memory-card game sequencer; `define MOVE_LIMIT_EN enables the MAX_MOVES budget
module memory_game_ctrl #(
   parameter int HOLD_CYCLES = 25_000_000,
   parameter int MAX_MOVES   = 40
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [47:0] layout,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_sel,
   output logic [3:0]  cursor,
   output logic [15:0] face_up,
   output logic [15:0] matched,
   output logic [7:0]  moves,
   output logic [3:0]  pairs,
   output logic        busy,
   output logic        game_won,
   output logic        game_lost
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_PICK1     = 3'd1;
   localparam logic [2:0] S_PICK2     = 3'd2;
   localparam logic [2:0] S_COMPARE   = 3'd3;
   localparam logic [2:0] S_SHOW      = 3'd4;
   localparam logic [2:0] S_DONE_WIN  = 3'd5;
   localparam logic [2:0] S_DONE_LOSE = 3'd6;

   logic [2:0]  r_state;
   logic [47:0] r_layout;
   logic [3:0]  r_cursor;
   logic [3:0]  r_first;
   logic [3:0]  r_second;
   logic [15:0] r_face_up;
   logic [15:0] r_matched;
   logic [7:0]  r_moves;
   logic [3:0]  r_pairs;
   logic [25:0] r_hold;

   logic        w_cursor_active;
   logic        w_sel_ok;
   logic        w_ids_equal;
   logic        w_out_of_moves;
   logic [3:0]  w_cursor_next;
   logic [7:0]  w_moves_inc;
   logic [5:0]  w_base_first;
   logic [5:0]  w_base_second;
   logic [15:0] w_cur_bit;
   logic [15:0] w_pair_bits;

   assign w_cursor_active = (r_state == S_PICK1) || (r_state == S_PICK2) ||
                            (r_state == S_COMPARE) || (r_state == S_SHOW);

   // Row and column wrap independently: each is a 2-bit field that rolls over.
   always_comb begin
      w_cursor_next = r_cursor;
      if (btn_up)
         w_cursor_next = {r_cursor[3:2] - 2'd1, r_cursor[1:0]};
      else if (btn_down)
         w_cursor_next = {r_cursor[3:2] + 2'd1, r_cursor[1:0]};
      else if (btn_left)
         w_cursor_next = {r_cursor[3:2], r_cursor[1:0] - 2'd1};
      else if (btn_right)
         w_cursor_next = {r_cursor[3:2], r_cursor[1:0] + 2'd1};
   end

   assign w_cur_bit     = 16'd1 << r_cursor;
   assign w_pair_bits   = (16'd1 << r_first) | (16'd1 << r_second);
   assign w_sel_ok      = btn_sel && !r_face_up[r_cursor];
   assign w_base_first  = {2'b00, r_first} * 6'd3;
   assign w_base_second = {2'b00, r_second} * 6'd3;
   assign w_ids_equal   = (r_layout[w_base_first +: 3] == r_layout[w_base_second +: 3]);
   assign w_moves_inc   = (r_moves == 8'hFF) ? r_moves : r_moves + 8'd1;

`ifdef MOVE_LIMIT_EN
   assign w_out_of_moves = (w_moves_inc == 8'(MAX_MOVES));
   assign game_lost      = (r_state == S_DONE_LOSE);
`else
   logic [7:0] w_unused_max_moves;
   assign w_unused_max_moves = 8'(MAX_MOVES);
   assign w_out_of_moves     = 1'b0;
   assign game_lost          = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_layout  <= '0;
         r_cursor  <= '0;
         r_first   <= '0;
         r_second  <= '0;
         r_face_up <= '0;
         r_matched <= '0;
         r_moves   <= '0;
         r_pairs   <= '0;
         r_hold    <= '0;
      end else if (start) begin
         r_state   <= S_PICK1;
         r_layout  <= layout;
         r_cursor  <= '0;
         r_face_up <= '0;
         r_matched <= '0;
         r_moves   <= '0;
         r_pairs   <= '0;
         r_hold    <= '0;
      end else begin
         // Select below uses the pre-move cursor, so a same-cycle direction applies afterwards.
         if (w_cursor_active)
            r_cursor <= w_cursor_next;
         case (r_state)
            S_PICK1: if (w_sel_ok) begin
               r_face_up <= r_face_up | w_cur_bit;
               r_first   <= r_cursor;
               r_state   <= S_PICK2;
            end
            S_PICK2: if (w_sel_ok) begin
               r_face_up <= r_face_up | w_cur_bit;
               r_second  <= r_cursor;
               r_state   <= S_COMPARE;
            end
            S_COMPARE: begin
               r_moves <= w_moves_inc;
               if (w_ids_equal) begin
                  r_matched <= r_matched | w_pair_bits;
                  r_pairs   <= r_pairs + 4'd1;
                  if (r_pairs == 4'd7)
                     r_state <= S_DONE_WIN;
                  else if (w_out_of_moves)
                     r_state <= S_DONE_LOSE;
                  else
                     r_state <= S_PICK1;
               end else if (w_out_of_moves) begin
                  r_state <= S_DONE_LOSE;
               end else begin
                  r_hold  <= 26'(HOLD_CYCLES - 1);
                  r_state <= S_SHOW;
               end
            end
            S_SHOW: begin
               if (r_hold == '0) begin
                  r_face_up <= r_face_up & ~w_pair_bits;
                  r_state   <= S_PICK1;
               end else begin
                  r_hold <= r_hold - 26'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign cursor   = r_cursor;
   assign face_up  = r_face_up;
   assign matched  = r_matched;
   assign moves    = r_moves;
   assign pairs    = r_pairs;
   assign busy     = (r_state == S_COMPARE) || (r_state == S_SHOW);
   assign game_won = (r_state == S_DONE_WIN);

endmodule
